// File: rtl/mlp_layer_sequencer.sv
// Sequencer for one dense int8 MLP layer around a single shared MAC: per output neuron it
// clears the MAC, streams N_IN weight/activation pairs, drains the MAC pipe, then requantises.
module mlp_layer_sequencer #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 7,
    localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int XA_W = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int BA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_relu_en,
    input  logic                    i_abort,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_w_rd,
    output logic [WA_W-1:0]         o_w_addr,
    input  logic signed [7:0]       i_w_data,
    output logic                    o_x_rd,
    output logic [XA_W-1:0]         o_x_addr,
    input  logic signed [7:0]       i_x_data,
    output logic                    o_b_rd,
    output logic [BA_W-1:0]         o_b_addr,
    input  logic signed [15:0]      i_b_data,
    output logic                    o_mac_clr,
    output logic                    o_mac_en,
    output logic signed [7:0]       o_mac_w,
    output logic signed [7:0]       o_mac_x,
    input  logic signed [ACC_W-1:0] i_mac_sum,
    output logic                    o_y_we,
    output logic [BA_W-1:0]         o_y_addr,
    output logic signed [7:0]       o_y_data,
    output logic [2:0]              o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic signed [ACC_W:0] SAT_HI = 127;
    localparam logic signed [ACC_W:0] SAT_LO = -128;

    state_t              r_state, w_next;
    logic [XA_W-1:0]     r_i;
    logic [BA_W-1:0]     r_o;
    logic [WA_W-1:0]     r_wa;
    logic                r_drain;
    logic                r_relu;
    logic                r_b_vld;
    logic signed [15:0]  r_bias;
    logic                r_mac_en;
    logic                r_done;

    logic                w_clr, w_rd, w_b_rd, w_we, w_last;
    logic signed [ACC_W:0] w_sum, w_shf;
    logic signed [7:0]   w_y;

    // Handshake: reads return data the cycle after *_rd; y_we is a single-cycle write strobe.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_rd   = 1'b0;
        w_b_rd = 1'b0;
        w_we   = 1'b0;
        w_last = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_CLEAR;
            S_CLEAR: begin
                w_clr  = 1'b1;
                w_b_rd = 1'b1;
                w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_rd = 1'b1;
                if (r_i == XA_W'(N_IN - 1)) w_next = S_DRAIN;
            end
            S_DRAIN: if (r_drain) w_next = S_WRITE;
            S_WRITE: begin
                w_we = 1'b1;
                if (r_o == BA_W'(N_OUT - 1)) begin
                    w_next = S_IDLE;
                    w_last = 1'b1;
                end else begin
                    w_next = S_CLEAR;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (i_abort && r_state != S_IDLE) begin
            w_next = S_IDLE;
            w_clr  = 1'b1;
            w_rd   = 1'b0;
            w_b_rd = 1'b0;
            w_we   = 1'b0;
            w_last = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_o      <= '0;
            r_wa     <= '0;
            r_drain  <= 1'b0;
            r_relu   <= 1'b0;
            r_b_vld  <= 1'b0;
            r_bias   <= '0;
            r_mac_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mac_en <= w_rd;
            r_b_vld  <= w_b_rd;
            r_done   <= w_last;
            if (r_b_vld) r_bias <= i_b_data;
            if (r_state == S_IDLE && i_start) begin
                r_relu <= i_relu_en;
                r_o    <= '0;
                r_wa   <= '0;
            end
            if (r_state == S_CLEAR) begin
                r_i     <= '0;
                r_drain <= 1'b0;
            end
            if (w_rd) begin
                r_i  <= r_i + XA_W'(1);
                r_wa <= r_wa + WA_W'(1);
            end
            if (r_state == S_DRAIN) r_drain <= 1'b1;
            if (w_we && w_next == S_CLEAR) r_o <= r_o + BA_W'(1);
        end
    end

    // Bias is added at full accumulator precision before the floor shift.
    assign w_sum = $signed({i_mac_sum[ACC_W-1], i_mac_sum})
                 + $signed({{(ACC_W-15){r_bias[15]}}, r_bias});
    assign w_shf = w_sum >>> SHIFT;

    always_comb begin
        w_y = w_shf[7:0];
        if (r_relu && w_shf < 0)  w_y = 8'sd0;
        else if (w_shf > SAT_HI)  w_y = 8'sd127;
        else if (w_shf < SAT_LO)  w_y = -8'sd128;
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_w_rd      = w_rd;
    assign o_w_addr    = w_rd ? r_wa : '0;
    assign o_x_rd      = w_rd;
    assign o_x_addr    = w_rd ? r_i : '0;
    assign o_b_rd      = w_b_rd;
    assign o_b_addr    = w_b_rd ? r_o : '0;
    assign o_mac_clr   = w_clr;
    assign o_mac_en    = r_mac_en;
    assign o_mac_w     = i_w_data;
    assign o_mac_x     = i_x_data;
    assign o_y_we      = w_we;
    assign o_y_addr    = w_we ? r_o : '0;
    assign o_y_data    = w_we ? w_y : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer (N_IN=4, N_OUT=2, SHIFT=1) with memory and MAC models and a
// write scoreboard fed by the directed tests.
module tb_mlp_layer_sequencer;

    localparam int N_IN = 4, N_OUT = 2, ACC_W = 20, SHIFT = 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, relu_en = 1'b0, abort = 1'b0;
    logic busy, done, w_rd, x_rd, b_rd, mac_clr, mac_en, y_we;
    logic [2:0] w_addr;
    logic [1:0] x_addr;
    logic [0:0] b_addr, y_addr;
    logic signed [7:0] w_data = '0, x_data = '0, mac_w, mac_x, y_data;
    logic signed [15:0] b_data = '0;
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0] prod;
    logic pv;
    logic [2:0] dbg_state;

    logic signed [7:0]  wmem [8];
    logic signed [7:0]  xmem [4];
    logic signed [15:0] bmem [2];

    logic [8:0] exp_q[$];
    int wr_cyc[$];
    int total = 0, bad = 0;
    int cyc = 0, t0 = 0;
    int wr_count = 0, done_count = 0, done_cyc = -1;

    mlp_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_relu_en(relu_en), .i_abort(abort),
        .o_busy(busy), .o_done(done),
        .o_w_rd(w_rd), .o_w_addr(w_addr), .i_w_data(w_data),
        .o_x_rd(x_rd), .o_x_addr(x_addr), .i_x_data(x_data),
        .o_b_rd(b_rd), .o_b_addr(b_addr), .i_b_data(b_data),
        .o_mac_clr(mac_clr), .o_mac_en(mac_en), .o_mac_w(mac_w), .o_mac_x(mac_x),
        .i_mac_sum(acc),
        .o_y_we(y_we), .o_y_addr(y_addr), .o_y_data(y_data), .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory models: one-cycle read latency
    always @(posedge clk) begin
        if (w_rd) w_data <= wmem[w_addr];
        if (x_rd) x_data <= xmem[x_addr];
        if (b_rd) b_data <= bmem[b_addr];
    end

    // MAC model: operand in cycle t visible in acc from t+2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; prod <= '0; pv <= 1'b0;
        end else if (mac_clr) begin
            acc <= '0; prod <= '0; pv <= 1'b0;
        end else begin
            pv   <= mac_en;
            prod <= mac_w * mac_x;
            if (pv) acc <= acc + ACC_W'(prod);
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (y_we) begin
            wr_count++;
            wr_cyc.push_back(cyc - t0);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", y_addr, y_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({y_addr, y_data} !== e) begin
                    bad++;
                    $display("FAIL y_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             y_addr, y_data, e[8], $signed(e[7:0]));
                end
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc - t0;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic start_layer(input logic relu);
        start = 1'b1; relu_en = relu; t0 = cyc;
        sync();
        start = 1'b0; relu_en = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - t0 < n) sync();
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_timeout", int'(seen), 1);
        sync();
    endtask

    task automatic load_t1();
        wmem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
        xmem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        bmem = '{16'sd0, 16'sd0};
    endtask

    // driver / directed tests
    initial begin
        int d0, w0;
        load_t1();
        #2;
        check("reset_outputs", int'({busy, done, w_rd, x_rd, b_rd, mac_clr, mac_en, y_we}), 0);
        check("reset_state", int'(dbg_state), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        sync();

        // T1: sum 10 >>> 1 = 5 on both neurons, write/done timing
        wr_cyc.delete(); d0 = done_count;
        push_exp(1'b0, 8'sd5); push_exp(1'b1, 8'sd5);
        start_layer(1'b0);
        check("busy_after_start", int'(busy), 1);
        wait_done();
        repeat (3) sync();
        check("t1_write_count", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) begin
            check("t1_first_write_cycle", wr_cyc[0], 8);
            check("t1_last_write_cycle", wr_cyc[1], 16);
        end
        check("t1_done_cycle", done_cyc, 17);
        check("t1_done_pulses", done_count - d0, 1);
        check("t1_busy_idle", int'(busy), 0);

        // T2: saturation high/low, then relu
        wmem = '{8'sd127, 8'sd127, 8'sd127, 8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127};
        xmem = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        push_exp(1'b0, 8'h7f); push_exp(1'b1, 8'h80);
        start_layer(1'b0); wait_done();
        push_exp(1'b0, 8'h7f); push_exp(1'b1, 8'h00);
        start_layer(1'b1); wait_done();

        // T3: floor rounding -3 >>> 1 = -2; bias +5 gives 2 >>> 1 = 1
        wmem = '{-8'sd3, 8'sd0, 8'sd0, 8'sd0, -8'sd3, 8'sd0, 8'sd0, 8'sd0};
        xmem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        bmem = '{16'sd0, 16'sd5};
        push_exp(1'b0, 8'hfe); push_exp(1'b1, 8'h01);
        start_layer(1'b0); wait_done();

        // T4: distinct weights per neuron, negative and large biases
        wmem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, -8'sd1, -8'sd2, -8'sd3, -8'sd4};
        xmem = '{8'sd4, 8'sd3, 8'sd2, 8'sd1};
        bmem = '{-16'sd1, 16'sd300};
        push_exp(1'b0, 8'd9); push_exp(1'b1, 8'h7f);
        start_layer(1'b0); wait_done();

        // T5: abort in third ISSUE cycle of neuron 1
        load_t1();
        d0 = done_count; w0 = wr_count;
        push_exp(1'b0, 8'sd5);
        start_layer(1'b0);
        wait_rel(12);
        check("abort_in_issue", int'(dbg_state), 2);
        abort = 1'b1; #1;
        check("abort_mac_clr", int'(mac_clr), 1);
        sync();
        abort = 1'b0;
        check("abort_busy_low", int'(busy), 0);
        repeat (20) sync();
        check("abort_writes", wr_count - w0, 1);
        check("abort_no_done", done_count - d0, 0);
        push_exp(1'b0, 8'sd5); push_exp(1'b1, 8'sd5);
        start_layer(1'b0); wait_done();

        // T6: start during ISSUE ignored; start in done cycle accepted
        d0 = done_count; w0 = wr_count;
        push_exp(1'b0, 8'sd5); push_exp(1'b1, 8'sd5);
        start_layer(1'b0);
        wait_rel(4);
        start = 1'b1; sync(); start = 1'b0;
        wait_rel(17);
        check("t6_done_at_17", int'(done), 1);
        check("t6_writes", wr_count - w0, 2);
        push_exp(1'b0, 8'sd5); push_exp(1'b1, 8'sd5);
        start_layer(1'b0);
        check("t6_restart_clear", int'(dbg_state), 1);
        wait_done();
        repeat (3) sync();
        check("t6_done_pulses", done_count - d0, 2);

        // T7: reset during DRAIN
        d0 = done_count; w0 = wr_count;
        start_layer(1'b0);
        wait_rel(6);
        check("t7_in_drain", int'(dbg_state), 3);
        #2 rst_n = 1'b0; #1;
        check("t7_reset_outputs", int'({busy, done, w_rd, x_rd, b_rd, mac_clr, mac_en, y_we}), 0);
        check("t7_reset_y_data", int'(y_data), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        sync();
        check("t7_idle_after_release", int'(dbg_state), 0);
        repeat (30) sync();
        check("t7_no_writes", wr_count - w0, 0);
        check("t7_no_done", done_count - d0, 0);
        push_exp(1'b0, 8'sd5); push_exp(1'b1, 8'sd5);
        start_layer(1'b0); wait_done();

        repeat (3) sync();
        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Sequencer for one dense int8 MLP layer built around a single shared int8 multiply-accumulate neuron. For each output neuron it clears the MAC, streams N_IN weight/input pairs from the weight and activation memories, waits out the MAC pipeline, then adds bias, requantises to int8 with optional ReLU, and writes the result. It sits between the layer memories and the MAC and is started by the network-level controller once per layer.

## Interface
- N_IN, 16: inputs per neuron; legal range 1..31 with ACC_W=20, generally N_IN*16384 < 2^(ACC_W-1)
- N_OUT, 8: output neurons, ≥1
- ACC_W, 20: MAC accumulator width
- SHIFT, 7: requantisation arithmetic right shift, 0..ACC_W-1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin layer; honoured only in IDLE
- relu_en  in  1  sampled with accepted start
- abort  in  1  cancel layer; honoured only while busy
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final write
- w_rd / w_addr  out  1 / clog2(N_IN*N_OUT)  weight read, address o*N_IN+i
- w_data  in  8 signed  weight, valid one cycle after w_rd
- x_rd / x_addr  out  1 / clog2(N_IN)  activation read, address i
- x_data  in  8 signed  activation, valid one cycle after x_rd
- b_rd / b_addr  out  1 / clog2(N_OUT)  bias read, address o
- b_data  in  16 signed  bias, valid one cycle after b_rd
- mac_clr  out  1  synchronous clear of MAC product and accumulator
- mac_en  out  1  mac_w/mac_x valid this cycle
- mac_w, mac_x  out  8 signed  combinational pass-through of w_data, x_data
- mac_sum  in  ACC_W signed  MAC accumulator
- y_we / y_addr / y_data  out  1 / clog2(N_OUT) / 8 signed  result write

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, WRITE.
- IDLE: start=1 → CLEAR, o=0, latch relu_en.
- CLEAR (1 cycle): mac_clr=1, b_rd=1, b_addr=o; i=0; → ISSUE. bias_q captured from b_data next cycle.
- ISSUE (N_IN cycles): w_rd=x_rd=1, w_addr=o*N_IN+i, x_addr=i, i++; after i=N_IN-1 → DRAIN. mac_en is w_rd delayed one cycle.
- DRAIN (2 cycles): no reads; covers the final mac_en cycle plus MAC product→accumulate register stage. → WRITE.
- WRITE (1 cycle): s = sext(mac_sum)+sext(bias_q) in ACC_W+1 bits; t = s >>> SHIFT (floor); if relu_q and t<0, t=0; y_data = saturate t to [-128,127]; y_we=1, y_addr=o. If o=N_OUT-1 → IDLE with done=1 next cycle; else o++ → CLEAR.
- abort=1 in any busy state: next state IDLE, mac_clr=1 that cycle, no y_we, no done. abort in IDLE ignored.
- start while busy ignored. start in the cycle done is high is accepted (FSM already IDLE).
- Accumulator overflow outside legal N_IN is not detected.

## Timing
- Reset values: busy, done, all *_rd, mac_en, mac_clr, y_we = 0; all addresses, y_data = 0; FSM IDLE; counters 0.
- MAC contract: operand with mac_en in cycle t is included in mac_sum from cycle t+2 on. Last ISSUE cycle L → mac_en at L+1 → sum final at L+3 = WRITE.
- Per neuron: N_IN+4 cycles. start accepted at cycle 0 → first y_we at cycle N_IN+4, last at N_OUT*(N_IN+4), done at N_OUT*(N_IN+4)+1.
- busy rises the cycle after start acceptance, falls the cycle done rises.
- rst_n low mid-layer: all outputs to reset values immediately; no further writes; new start needed.

## Test plan
- N_IN=4, N_OUT=2, all w=1, x={1,2,3,4}, bias 0, SHIFT 0 → y_we at cycles 8 and 16, y_data=10 at y_addr 0 and 1; done at cycle 17 only.
- N_IN=4, w=127, x=127, bias 0, SHIFT 7 → sum 64516 → 504 → y_data=127; w=-127 → -128; same with relu_en=1 → 0.
- Floor rounding: mac sum -3 (w={-3,0,0,0}, x={1,..}), bias 0, SHIFT 1 → y_data=-2; bias +5 → sum 2 → y_data=1.
- abort in 3rd ISSUE cycle of neuron 1 → busy low next cycle, no y_we for neuron 1, done never pulses; subsequent start runs full layer with correct results (accumulator cleared).
- start pulsed during ISSUE ignored (write count unchanged); start in done cycle → new layer, CLEAR the following cycle.
- rst_n dropped during DRAIN → outputs zero same cycle, FSM IDLE after release, no spurious y_we or done.
